// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 8;
    localparam int FIFO_DEPTH_DEF  = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold
// flags, error pulses and optional first-word-fall-through read.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W_DEF,
    parameter int DEPTH     = FIFO_DEPTH_DEF,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] FULL_T = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_T   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_T   = (AW+1)'(AE_THRESH);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_sync_param: AF_THRESH out of range");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_param: AE_THRESH out of range");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_ok;
    logic              rd_ok;

    assign full         = (count == FULL_T);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_T);
    assign almost_empty = (count <= AE_T);

    // A write into a full FIFO is only legal when the head leaves on the same edge.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_en);

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .we     (wr_ok),
        .waddr  (wr_ptr),
        .wdata  (din),
        .raddr  (rd_ptr),
        .rdata  (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow  <= wr_en && !wr_ok;
            underflow <= rd_en && !rd_ok;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign dout = empty ? '0 : rd_data;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (!reset) begin
                dout_q <= '0;
            end else if (rd_ok) begin
                dout_q <= rd_data;
            end
        end

        assign dout = dout_q;
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: default standard-read instance
// plus a small 16-bit FWFT instance.
module tb_fifo_sync_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        a_wr = 1'b0, a_rd = 1'b0;
    logic [7:0]  a_din = '0, a_dout;
    logic        a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [4:0]  a_count;

    logic        b_wr = 1'b0, b_rd = 1'b0;
    logic [15:0] b_din = '0, b_dout;
    logic        b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [2:0]  b_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fifo_sync_param dut_a (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (a_wr),
        .rd_en        (a_rd),
        .din          (a_din),
        .dout         (a_dout),
        .full         (a_full),
        .empty        (a_empty),
        .almost_full  (a_af),
        .almost_empty (a_ae),
        .count        (a_count),
        .overflow     (a_ovf),
        .underflow    (a_udf)
    );

    fifo_sync_param #(
        .DATA_W    (16),
        .DEPTH     (4),
        .AF_THRESH (3),
        .AE_THRESH (1),
        .FWFT      (1)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (b_wr),
        .rd_en        (b_rd),
        .din          (b_din),
        .dout         (b_dout),
        .full         (b_full),
        .empty        (b_empty),
        .almost_full  (b_af),
        .almost_empty (b_ae),
        .count        (b_count),
        .overflow     (b_ovf),
        .underflow    (b_udf)
    );

    // flag vector order: full, empty, almost_full, almost_empty, overflow, underflow
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc();
        cyc();
        vectors++;
        if ({a_full, a_empty, a_af, a_ae, a_ovf, a_udf} !== 6'b010100) begin
            miscompares++;
            $display("FAIL reset_flags_a: got %b want 010100",
                     {a_full, a_empty, a_af, a_ae, a_ovf, a_udf});
        end
        vectors++;
        if (a_count !== 5'd0 || a_dout !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_cnt_dout_a: got %0d/%h want 0/00", a_count, a_dout);
        end
        vectors++;
        if ({b_full, b_empty, b_ovf, b_udf} !== 4'b0100 || b_count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_b: got %b cnt %0d want 0100 cnt 0",
                     {b_full, b_empty, b_ovf, b_udf}, b_count);
        end
        reset = 1'b1;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            a_wr  = 1'b1;
            a_din = 8'hFF - 8'(i);
            cyc();
            vectors++;
            if (a_count !== 5'(i + 1)) begin
                miscompares++;
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, a_count, i + 1);
            end
            vectors++;
            if ({a_full, a_af, a_ae} !== {i + 1 == 16, i + 1 >= 14, i + 1 <= 2}) begin
                miscompares++;
                $display("FAIL fill_flags[%0d]: got %b want %b", i,
                         {a_full, a_af, a_ae}, {i + 1 == 16, i + 1 >= 14, i + 1 <= 2});
            end
        end
        a_din = 8'h11;
        cyc();
        a_wr = 1'b0;
        vectors++;
        if ({a_ovf, a_full, a_count} !== {1'b1, 1'b1, 5'd16}) begin
            miscompares++;
            $display("FAIL overflow_pulse: got ovf %b full %b cnt %0d want 1 1 16",
                     a_ovf, a_full, a_count);
        end
        cyc();
        vectors++;
        if (a_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_width: got %b want 0", a_ovf);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            a_rd = 1'b1;
            cyc();
            vectors++;
            if (a_dout !== 8'hFF - 8'(i)) begin
                miscompares++;
                $display("FAIL drain_dout[%0d]: got %h want %h", i, a_dout, 8'hFF - 8'(i));
            end
        end
        a_rd = 1'b0;
        vectors++;
        if ({a_empty, a_ae, a_udf} !== 3'b110 || a_count !== 5'd0) begin
            miscompares++;
            $display("FAIL drain_end: got %b cnt %0d want 110 cnt 0",
                     {a_empty, a_ae, a_udf}, a_count);
        end
    endtask

    task automatic test_underflow();
        a_rd = 1'b1;
        cyc();
        a_rd = 1'b0;
        vectors++;
        if ({a_udf, a_dout, a_count} !== {1'b1, 8'hF0, 5'd0}) begin
            miscompares++;
            $display("FAIL underflow_pulse: got udf %b dout %h cnt %0d want 1 f0 0",
                     a_udf, a_dout, a_count);
        end
        cyc();
        vectors++;
        if (a_udf !== 1'b0 || a_dout !== 8'hF0) begin
            miscompares++;
            $display("FAIL underflow_width: got udf %b dout %h want 0 f0", a_udf, a_dout);
        end
    endtask

    task automatic test_back_to_back_full();
        logic [7:0] exp_q [$];
        for (int i = 0; i < 16; i++) begin
            a_wr  = 1'b1;
            a_din = 8'(i);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            a_wr  = 1'b1;
            a_rd  = 1'b1;
            a_din = 8'hAA;
            cyc();
            vectors++;
            if ({a_dout, a_count, a_ovf} !== {8'(i), 5'd16, 1'b0}) begin
                miscompares++;
                $display("FAIL full_rw[%0d]: got dout %h cnt %0d ovf %b want %h 16 0",
                         i, a_dout, a_count, a_ovf, 8'(i));
            end
        end
        a_wr = 1'b0;
        for (int i = 4; i < 16; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hAA);
        for (int i = 0; i < 16; i++) begin
            a_rd = 1'b1;
            cyc();
            vectors++;
            if (a_dout !== exp_q[i]) begin
                miscompares++;
                $display("FAIL tail_dout[%0d]: got %h want %h", i, a_dout, exp_q[i]);
            end
        end
        a_rd = 1'b0;
        vectors++;
        if (a_empty !== 1'b1 || a_count !== 5'd0) begin
            miscompares++;
            $display("FAIL tail_empty: got %b cnt %0d want 1 0", a_empty, a_count);
        end
    endtask

    task automatic test_fwft();
        b_wr  = 1'b1;
        b_din = 16'h1234;
        cyc();
        b_wr = 1'b0;
        vectors++;
        if ({b_dout, b_empty, b_count} !== {16'h1234, 1'b0, 3'd1}) begin
            miscompares++;
            $display("FAIL fwft_visible: got %h e%b c%0d want 1234 e0 c1",
                     b_dout, b_empty, b_count);
        end
        cyc();
        vectors++;
        if (b_dout !== 16'h1234) begin
            miscompares++;
            $display("FAIL fwft_hold: got %h want 1234", b_dout);
        end
        b_rd = 1'b1;
        cyc();
        b_rd = 1'b0;
        vectors++;
        if (b_empty !== 1'b1 || b_count !== 3'd0) begin
            miscompares++;
            $display("FAIL fwft_pop: got e%b c%0d want e1 c0", b_empty, b_count);
        end
        b_wr  = 1'b1;
        b_rd  = 1'b1;
        b_din = 16'h5678;
        cyc();
        b_rd  = 1'b0;
        b_din = 16'hBEEF;
        vectors++;
        if ({b_udf, b_count, b_dout} !== {1'b1, 3'd1, 16'h5678}) begin
            miscompares++;
            $display("FAIL fwft_wr_rd_empty: got u%b c%0d %h want u1 c1 5678",
                     b_udf, b_count, b_dout);
        end
        cyc();
        b_wr = 1'b0;
        vectors++;
        if ({b_udf, b_count, b_dout} !== {1'b0, 3'd2, 16'h5678}) begin
            miscompares++;
            $display("FAIL fwft_second: got u%b c%0d %h want u0 c2 5678",
                     b_udf, b_count, b_dout);
        end
        b_rd = 1'b1;
        cyc();
        vectors++;
        if (b_dout !== 16'hBEEF || b_count !== 3'd1) begin
            miscompares++;
            $display("FAIL fwft_advance: got %h c%0d want beef c1", b_dout, b_count);
        end
        cyc();
        b_rd = 1'b0;
        vectors++;
        if (b_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL fwft_drained: got e%b want e1", b_empty);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 9; i++) begin
            a_wr  = 1'b1;
            a_din = 8'h20 + 8'(i);
            cyc();
        end
        vectors++;
        if (a_count !== 5'd9) begin
            miscompares++;
            $display("FAIL pre_reset_count: got %0d want 9", a_count);
        end
        reset = 1'b0;
        a_din = 8'h77;
        cyc();
        reset = 1'b1;
        a_wr  = 1'b0;
        vectors++;
        if ({a_full, a_empty, a_af, a_ae, a_ovf, a_udf} !== 6'b010100) begin
            miscompares++;
            $display("FAIL mid_reset_flags: got %b want 010100",
                     {a_full, a_empty, a_af, a_ae, a_ovf, a_udf});
        end
        vectors++;
        if (a_count !== 5'd0 || a_dout !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset_cnt: got %0d/%h want 0/00", a_count, a_dout);
        end
        a_wr  = 1'b1;
        a_din = 8'h5C;
        cyc();
        a_wr = 1'b0;
        a_rd = 1'b1;
        cyc();
        a_rd = 1'b0;
        vectors++;
        if ({a_dout, a_empty, a_count} !== {8'h5C, 1'b1, 5'd0}) begin
            miscompares++;
            $display("FAIL post_reset_rd: got %h e%b c%0d want 5c e1 c0",
                     a_dout, a_empty, a_count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain();
        test_underflow();
        test_back_to_back_full();
        test_fwft();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
